load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the execute stage.
- Drives the word-only, word-aligned data memory port.
- Implements RV32I byte and halfword access: loads use lane extraction with sign/zero extension; sub-word stores use read-modify-write.
- Sits between the execute stage and the data memory, which has combinational read and a write on posedge.

Parameters:
- ADDR_W, 32, byte address width on both the request side and the memory side.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present; sampled only when req_ready=1.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low byte/half is used for sub-word stores.
- resp_done  out  1  one-cycle pulse: request finished.
- resp_err  out  1  valid with resp_done: misaligned or illegal funct3.
- resp_rdata  out  32  extended load data; valid with resp_done; 0 for stores and errors.
- mem_access_addr  out  ADDR_W  word address, low 2 bits always 0.
- mem_in  out  32  write data.
- mem_write_en  out  1  write strobe.
- mem_read_en  out  1  read strobe.
- mem_out  in  32  read data, combinational from mem_access_addr/mem_read_en.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all request registers cleared.
  - req_ready=1; resp_done=0, resp_err=0, resp_rdata=0.
  - mem_access_addr=0, mem_in=0, mem_write_en=0, mem_read_en=0.
- States: IDLE, RD, WR, RESP. Outputs are decoded from the state and the captured request (Moore).
- IDLE:
  - On posedge with req_valid=1, capture write/funct3/addr/wdata.
  - Illegal funct3 (011, 110, 111, or a store with 100/101) -> RESP with err.
  - Misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0) -> RESP with err. No memory strobe is ever raised for an error.
  - Load, or store B/H -> RD. Store W -> WR.
- RD:
  - mem_read_en=1; mem_access_addr={addr[ADDR_W-1:2],2'b00}.
  - On posedge, capture mem_out into word_buf.
  - Next state: WR for a store, RESP for a load.
- WR:
  - mem_write_en=1; same aligned address.
  - mem_in = merged word: word_buf with lane(s) replaced for B/H, or req_wdata for W.
  - Next state: RESP.
- RESP:
  - resp_done=1 for exactly one cycle; resp_err and resp_rdata are valid.
  - Next state: IDLE. A new request is accepted no earlier than the next IDLE cycle.
- Lanes are little-endian: byte k = bits [8k+7:8k]; half h = bits [16h+15:16h] with h=addr[1].
- Load extension: B and H sign-extend to 32 bits; BU and HU zero-extend.
- Latency, counted as cycles from the acceptance edge to resp_done high:
  - Load: 2.
  - Store W: 2.
  - Store B/H: 3.
  - Error: 1.
- Strobes are never both high in the same cycle. The enable and address are stable for the whole strobe cycle.
- Reset mid-operation: strobes drop immediately (async). A write whose posedge has not yet occurred does not complete. No resp_done is issued after reset.
- req_valid outside IDLE is ignored. The requester must hold the request until it sees req_ready.
- Upper address bits are passed through unchanged; wrap-around is the memory's responsibility.

Decomposition:
- Package lsu_pkg:
  - State encoding: IDLE=2'd0, RD=2'd1, WR=2'd2, RESP=2'd3.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One combinational sub-module, lsu_align:
  - Inputs: funct3, addr[1:0], word, wdata.
  - Outputs: load_data (extended) and merge_word (store).
  - Keeps lane logic out of the FSM.

Test Plan:
1. Memory word 0x10 preloaded 0x8844_2211. LB 0x13 -> rdata 0xFFFF_FF88, err=0, done 2 cycles after acceptance. LBU 0x13 -> 0x0000_0088.
2. Same word. LH 0x12 -> 0xFFFF_8844. LHU 0x10 -> 0x0000_2211. LW 0x10 -> 0x8844_2211.
3. SB wdata 0xAABB_CCDD to 0x11 -> one RD cycle then one WR cycle with mem_in 0x8844_DD11. A following LW 0x10 returns 0x8844_DD11.
4. SW 0x1234_5678 to 0x14 -> no read strobe; WR cycle mem_in 0x1234_5678, addr 0x14. done 2 cycles after acceptance.
5. Error cases:
   - LW 0x16 -> done+err 1 cycle after acceptance, both strobes 0 throughout, rdata 0.
   - SH 0x11 -> err.
   - funct3 011 -> err.
6. Issue SB, assert rst_n=0 during RD -> strobes 0 immediately, memory unchanged, req_ready=1 after release, no done pulse. Back-to-back requests held valid -> second accepted only in IDLE after RESP.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I funct3 access-size codes and the request legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // A request is rejected for an unknown size code, an unsigned store,
  // or an address not aligned to its access size.
  function automatic logic req_is_err(input logic       write,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic err;
    err = 1'b1;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_BU:   err = write;
      F3_H:    err = addr_lo[0];
      F3_HU:   err = write | addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit: the request/response channel from
// the execute stage and the word-wide data-memory port.
interface lsu_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_done;
  logic              resp_err;
  logic [31:0]       resp_rdata;

  // Execute stage issues requests.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_done, resp_err, resp_rdata
  );

  // Load/store unit serves them.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_done, resp_err, resp_rdata
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_access_addr;
  logic [31:0]       mem_in;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [31:0]       mem_out;

  // Load/store unit drives the memory port.
  modport master (
    output mem_access_addr, mem_in, mem_write_en, mem_read_en,
    input  mem_out
  );

  // Data memory responds with combinational read data.
  modport slave (
    input  mem_access_addr, mem_in, mem_write_en, mem_read_en,
    output mem_out
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Little-endian lane logic: extracts and extends load data from a memory
// word, and builds the merged word written back for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word[{addr_lo, 3'b000} +: 8];
  assign half_lane = addr_lo[1] ? word[31:16] : word[15:0];

  // Select the addressed lane and sign- or zero-extend it.
  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'h0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'h0, half_lane};
      F3_W:    load_data = word;
      default: load_data = 32'h0;
    endcase
  end

  // Each byte lane of the store word either keeps the old memory byte or
  // takes the matching byte of the store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      localparam logic       HALF = 1'(gi / 2);
      localparam int         HB   = 8 * (gi % 2);

      logic       sel;
      logic [7:0] src;

      // Decide whether this lane is overwritten and by which store byte.
      always_comb begin
        sel = 1'b0;
        src = 8'h00;
        case (funct3)
          F3_B, F3_BU: begin
            sel = (addr_lo == LANE);
            src = wdata[7:0];
          end
          F3_H, F3_HU: begin
            sel = (addr_lo[1] == HALF);
            src = wdata[HB +: 8];
          end
          F3_W: begin
            sel = 1'b1;
            src = wdata[8*gi +: 8];
          end
          default: begin
            sel = 1'b0;
            src = 8'h00;
          end
        endcase
      end

      assign merge_word[8*gi +: 8] = sel ? src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, performs word-aligned
// memory reads/writes (read-modify-write for sub-word stores) and returns
// extended load data with a one-cycle completion pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  lsu_state_t        state_reg;
  lsu_state_t        state_next;

  logic              write_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;
  logic [31:0]       word_buf_reg;

  logic [31:0]       load_data;
  logic [31:0]       merge_word;
  logic [ADDR_W-1:0] word_addr;

  logic              ready_out;
  logic              done_out;
  logic              err_out;
  logic [31:0]       rdata_out;
  logic [ADDR_W-1:0] maddr_out;
  logic [31:0]       min_out;
  logic              we_out;
  logic              re_out;

  assign word_addr = {addr_reg[ADDR_W-1:2], 2'b00};

  lsu_align u_align (
    .funct3     (funct3_reg),
    .addr_lo    (addr_reg[1:0]),
    .word       (word_buf_reg),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the request on acceptance and the memory word during a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg    <= 1'b0;
      funct3_reg   <= 3'b000;
      addr_reg     <= '0;
      wdata_reg    <= 32'h0;
      err_reg      <= 1'b0;
      word_buf_reg <= 32'h0;
    end else begin
      if (state_reg == IDLE && req.req_valid) begin
        write_reg  <= req.req_write;
        funct3_reg <= req.req_funct3;
        addr_reg   <= req.req_addr;
        wdata_reg  <= req.req_wdata;
        err_reg    <= req_is_err(req.req_write, req.req_funct3, req.req_addr[1:0]);
      end
      if (state_reg == RD) begin
        word_buf_reg <= mem.mem_out;
      end
    end
  end

  // Next-state decode and Moore outputs from state plus captured request.
  always_comb begin
    state_next = state_reg;
    ready_out  = 1'b0;
    done_out   = 1'b0;
    err_out    = 1'b0;
    rdata_out  = 32'h0;
    maddr_out  = '0;
    min_out    = 32'h0;
    we_out     = 1'b0;
    re_out     = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_out = 1'b1;
        if (req.req_valid) begin
          if (req_is_err(req.req_write, req.req_funct3, req.req_addr[1:0])) begin
            state_next = RESP;
          end else if (req.req_write && req.req_funct3 == F3_W) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        re_out     = 1'b1;
        maddr_out  = word_addr;
        state_next = write_reg ? WR : RESP;
      end
      WR: begin
        we_out     = 1'b1;
        maddr_out  = word_addr;
        min_out    = merge_word;
        state_next = RESP;
      end
      RESP: begin
        done_out   = 1'b1;
        err_out    = err_reg;
        rdata_out  = (err_reg || write_reg) ? 32'h0 : load_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req.req_ready       = ready_out;
  assign req.resp_done       = done_out;
  assign req.resp_err        = err_out;
  assign req.resp_rdata      = rdata_out;
  assign mem.mem_access_addr = maddr_out;
  assign mem.mem_in          = min_out;
  assign mem.mem_write_en    = we_out;
  assign mem.mem_read_en     = re_out;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a simple data memory, a
// request-level reference model checked every cycle, and directed
// transactions with hand-computed results.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_req_if #(.ADDR_W(32)) rq ();
  lsu_mem_if #(.ADDR_W(32)) mb ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rq),
    .mem   (mb)
  );

  // Data memory: combinational read, write on posedge.
  logic [31:0] mem_arr [64];
  assign mb.mem_out = mb.mem_read_en ? mem_arr[mb.mem_access_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (mb.mem_write_en) mem_arr[mb.mem_access_addr[7:2]] <= mb.mem_in;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_rd, m_wr, m_done;
  bit          m_err;
  logic [31:0] m_rdata, m_wdata, m_aaddr;

  // Request-level prediction: size/sign rules, alignment, lane arithmetic.
  function automatic void predict(input bit w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output bit err, output logic [31:0] rdata,
                                  output logic [31:0] merged);
    int size; bit uns; bit legal; int sh;
    logic [31:0] word, mask, v;
    legal = 1'b1; uns = 1'b0; size = 4;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1'b1; end
      3'd5: begin size = 2; uns = 1'b1; end
      default: legal = 1'b0;
    endcase
    err = !legal || (w && uns) || ((a % size) != 0);
    word = ref_mem[a[7:2]];
    sh = 8 * int'(a % 4);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v = (word >> sh) & mask;
    if (!uns && size < 4 && v[8*size-1]) v = v | ~mask;
    rdata = (err || w) ? 32'h0 : v;
    merged = (word & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // Model advance: commit the write that just happened, accept new requests.
  always @(posedge clk) begin
    bit e; logic [31:0] rd, mg;
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      if (m_active && m_wr == cyc - 1) ref_mem[m_aaddr[7:2]] = m_wdata;
      if ((!m_active || cyc - 1 > m_done) && rq.req_valid) begin
        predict(rq.req_write, rq.req_funct3, rq.req_addr, rq.req_wdata, e, rd, mg);
        m_active = 1'b1; m_err = e; m_rdata = rd; m_wdata = mg;
        m_aaddr = rq.req_addr & 32'hFFFF_FFFC;
        if (e) begin
          m_rd = -1; m_wr = -1; m_done = cyc;
        end else if (!rq.req_write) begin
          m_rd = cyc; m_wr = -1; m_done = cyc + 1;
        end else if (rq.req_funct3 == 3'd2) begin
          m_rd = -1; m_wr = cyc; m_done = cyc + 1;
        end else begin
          m_rd = cyc; m_wr = cyc + 1; m_done = cyc + 2;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  bit c_idle, c_rd, c_wr, c_done;
  always @(negedge clk) begin
    c_idle = !rst_n || !m_active || cyc > m_done;
    c_rd   = !c_idle && cyc == m_rd;
    c_wr   = !c_idle && cyc == m_wr;
    c_done = !c_idle && cyc == m_done;
    chk("ctrl{rdy,re,we,done}",
        {28'h0, rq.req_ready, mb.mem_read_en, mb.mem_write_en, rq.resp_done},
        {28'h0, c_idle, c_rd, c_wr, c_done});
    if (c_rd || c_wr) chk("mem_addr", mb.mem_access_addr, m_aaddr);
    if (c_wr) chk("mem_in", mb.mem_in, m_wdata);
    if (c_done) begin
      chk("model_rdata", rq.resp_rdata, m_rdata);
      chk("model_err", {31'h0, rq.resp_err}, {31'h0, m_err});
    end
  end

  // Issue one request, wait for completion, check literal expectations.
  task automatic run(input string name, input bit w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat);
    int n; bit seen; logic [31:0] rd; logic er;
    rq.req_valid = 1'b1; rq.req_write = w; rq.req_funct3 = f3;
    rq.req_addr = a; rq.req_wdata = wd;
    n = 0;
    while (!rq.req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      chk({name, "_ready_timeout"}, 32'd0, 32'd1);
      rq.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    n = 0; seen = 1'b0; rd = 32'h0; er = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk); n++;
      if (n == 1) rq.req_valid = 1'b0;
      if (rq.resp_done) begin seen = 1'b1; rd = rq.resp_rdata; er = rq.resp_err; end
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_rdata"}, rd, exp_rdata);
    chk({name, "_err"}, {31'h0, er}, {31'h0, exp_err});
    $display("txn %s addr=%h wdata=%h rdata=%h err=%0d latency=%0d", name, a, wd, rd, er, n);
  endtask

  initial begin
    int a1, a2, n, dones;
    for (int i = 0; i < 64; i++) begin mem_arr[i] = 32'h0; ref_mem[i] = 32'h0; end
    mem_arr[4] = 32'h8844_2211; ref_mem[4] = 32'h8844_2211;
    mem_arr[8] = 32'hCAFE_F00D; ref_mem[8] = 32'hCAFE_F00D;
    rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_funct3 = 3'b000;
    rq.req_addr = 32'h0; rq.req_wdata = 32'h0;

    #1;
    chk("reset_flags", {27'h0, rq.req_ready, rq.resp_done, rq.resp_err, mb.mem_read_en, mb.mem_write_en}, 32'h10);
    chk("reset_rdata", rq.resp_rdata, 32'h0);
    chk("reset_addr", mb.mem_access_addr, 32'h0);
    chk("reset_mem_in", mb.mem_in, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("LB_13",  0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF88, 0, 2);
    run("LBU_13", 0, 3'b100, 32'h13, 32'h0, 32'h0000_0088, 0, 2);
    run("LH_12",  0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8844, 0, 2);
    run("LHU_10", 0, 3'b101, 32'h10, 32'h0, 32'h0000_2211, 0, 2);
    run("LW_10",  0, 3'b010, 32'h10, 32'h0, 32'h8844_2211, 0, 2);
    run("SB_11",  1, 3'b000, 32'h11, 32'hAABB_CCDD, 32'h0, 0, 3);
    chk("mem_after_SB", mem_arr[4], 32'h8844_DD11);
    run("LW_10b", 0, 3'b010, 32'h10, 32'h0, 32'h8844_DD11, 0, 2);
    run("SW_14",  1, 3'b010, 32'h14, 32'h1234_5678, 32'h0, 0, 2);
    run("LW_14",  0, 3'b010, 32'h14, 32'h0, 32'h1234_5678, 0, 2);
    run("SH_16",  1, 3'b001, 32'h16, 32'h0000_BEEF, 32'h0, 0, 3);
    run("LHU_16", 0, 3'b101, 32'h16, 32'h0, 32'h0000_BEEF, 0, 2);
    run("LB_15",  0, 3'b000, 32'h15, 32'h0, 32'h0000_0056, 0, 2);
    run("LW_16",  0, 3'b010, 32'h16, 32'h0, 32'h0, 1, 1);
    run("SH_11",  1, 3'b001, 32'h11, 32'h1, 32'h0, 1, 1);
    run("F3_011", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1);
    run("SBU_10", 1, 3'b100, 32'h10, 32'h1, 32'h0, 1, 1);
    run("LH_13",  0, 3'b001, 32'h13, 32'h0, 32'h0, 1, 1);
    chk("mem_after_errs", mem_arr[4], 32'h8844_DD11);

    // Back-to-back: second request held valid while the first is in flight.
    rq.req_valid = 1'b1; rq.req_write = 1'b0; rq.req_funct3 = 3'b010; rq.req_addr = 32'h10;
    n = 0;
    while (!rq.req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 a1 = cyc;
    @(negedge clk);
    rq.req_funct3 = 3'b100; rq.req_addr = 32'h13;
    n = 0;
    while (!rq.req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 a2 = cyc;
    chk("b2b_accept_gap", a2 - a1, 32'd3);
    $display("txn b2b LW_10 then LBU_13 accept_gap=%0d", a2 - a1);
    @(negedge clk); rq.req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during the read phase of a byte store.
    rq.req_valid = 1'b1; rq.req_write = 1'b1; rq.req_funct3 = 3'b000;
    rq.req_addr = 32'h21; rq.req_wdata = 32'h0000_0055;
    n = 0;
    while (!rq.req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #3;
    chk("rd_before_rst", {31'h0, mb.mem_read_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_strobes", {30'h0, mb.mem_read_en, mb.mem_write_en}, 32'h0);
    rq.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'h0, rq.req_ready}, 32'h1);
    dones = 0;
    repeat (6) begin @(negedge clk); if (rq.resp_done) dones++; end
    chk("no_done_after_rst", dones, 32'd0);
    chk("mem_after_rst", mem_arr[8], 32'hCAFE_F00D);
    $display("txn SB_21 aborted by reset dones=%0d mem=%h", dones, mem_arr[8]);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
